// File: rtl/fetch_branch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_branch_sequencer
// Brief    : Multi-cycle fetch/decode/branch sequencer owning PC and IR for
//            the 16-bit accumulator processor.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_branch_sequencer #(
    parameter logic [15:0] RESET_PC      = 16'h0000,
    parameter logic [15:0] PC_STEP       = 16'd2,
    parameter int          FETCH_TIMEOUT = 15
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        RUN,
    output logic        MEM_REQ,
    output logic [15:0] MEM_ADDR,
    input  logic [15:0] MEM_RDATA,
    input  logic        MEM_ACK,
    output logic [15:0] IR,
    input  logic [15:0] SEOUT,
    input  logic        ACC_ZERO,
    input  logic        ACC_NEG,
    output logic        EX_START,
    input  logic        EX_DONE,
    output logic [15:0] PC,
    output logic        BRANCH_TAKEN,
    output logic        FAULT,
    output logic        BUSY
);

    localparam logic [7:0] C_TO_LAST = 8'(FETCH_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXEC    = 3'd3,
        S_WAIT_EX = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_pc;
    logic [15:0] r_ir;
    logic        r_fault;
    logic [7:0]  r_cnt;

    logic        w_cond;
    logic        w_timeout;
    logic        w_mem_req;
    logic        w_ex_start;
    logic        w_br_taken;

    always_comb begin
        w_cond = 1'b0;
        case (r_ir[14:13])
            2'b00:   w_cond = 1'b1;
            2'b01:   w_cond = ACC_ZERO;
            2'b10:   w_cond = ACC_NEG;
            default: w_cond = ~ACC_ZERO;
        endcase
    end

    // Last permitted FETCH cycle without an ack
    assign w_timeout = (r_cnt == C_TO_LAST);

    always_comb begin
        w_next     = r_state;
        w_mem_req  = 1'b0;
        w_ex_start = 1'b0;
        w_br_taken = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (RUN && !r_fault) w_next = S_FETCH;
            end
            S_FETCH: begin
                w_mem_req = 1'b1;
                if (MEM_ACK)        w_next = S_DECODE;
                else if (w_timeout) w_next = S_IDLE;
            end
            S_DECODE: w_next = S_EXEC;
            S_EXEC: begin
                if (r_ir[15]) begin
                    w_br_taken = w_cond;
                    w_next     = RUN ? S_FETCH : S_IDLE;
                end else begin
                    w_ex_start = 1'b1;
                    w_next     = S_WAIT_EX;
                end
            end
            S_WAIT_EX: begin
                if (EX_DONE) w_next = RUN ? S_FETCH : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_ir    <= 16'h0000;
            r_fault <= 1'b0;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_FETCH: begin
                    if (MEM_ACK) begin
                        r_ir  <= MEM_RDATA;
                        r_cnt <= 8'd0;
                    end else if (w_timeout) begin
                        r_fault <= 1'b1;
                        r_cnt   <= 8'd0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_EXEC: begin
                    // Branch target is relative to the branch's own address
                    if (r_ir[15]) r_pc <= w_cond ? (r_pc + SEOUT) : (r_pc + PC_STEP);
                end
                S_WAIT_EX: begin
                    if (EX_DONE) r_pc <= r_pc + PC_STEP;
                end
                default: ;
            endcase
        end
    end

    assign MEM_REQ      = w_mem_req;
    assign MEM_ADDR     = r_pc;
    assign IR           = r_ir;
    assign PC           = r_pc;
    assign EX_START     = w_ex_start;
    assign BRANCH_TAKEN = w_br_taken;
    assign FAULT        = r_fault;
    assign BUSY         = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fetch_branch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_branch_sequencer
// Brief    : Self-checking bench with an instruction-level PC reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_branch_sequencer;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        RUN = 1'b0;
    logic        MEM_REQ;
    logic [15:0] MEM_ADDR;
    logic [15:0] MEM_RDATA = 16'h0000;
    logic        MEM_ACK = 1'b0;
    logic [15:0] IR;
    logic [15:0] SEOUT;
    logic        ACC_ZERO = 1'b0;
    logic        ACC_NEG = 1'b0;
    logic        EX_START;
    logic        EX_DONE = 1'b0;
    logic [15:0] PC;
    logic        BRANCH_TAKEN;
    logic        FAULT;
    logic        BUSY;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] m_pc = 16'h0000;

    always #5 CLK = ~CLK;

    // Sign extender: 11-bit word offset scaled to bytes
    assign SEOUT = {{4{IR[10]}}, IR[10:0], 1'b0};

    fetch_branch_sequencer dut (
        .CLK(CLK), .RST_N(RST_N), .RUN(RUN),
        .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK),
        .IR(IR), .SEOUT(SEOUT), .ACC_ZERO(ACC_ZERO), .ACC_NEG(ACC_NEG),
        .EX_START(EX_START), .EX_DONE(EX_DONE), .PC(PC),
        .BRANCH_TAKEN(BRANCH_TAKEN), .FAULT(FAULT), .BUSY(BUSY)
    );

    task automatic do_reset();
        @(negedge CLK);
        RST_N = 1'b0; RUN = 1'b0; MEM_ACK = 1'b0; EX_DONE = 1'b0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        m_pc = 16'h0000;
    endtask

    // One full instruction: fetch, decode, execute/branch, compare PC with model
    task automatic run_instr(input logic [15:0] instr, input bit az, input bit an,
                             input int ack_dly, input int ex_dly, input bit run_next);
        bit          br;
        bit          tk;
        int          off;
        logic [15:0] exp_pc;
        RUN = 1'b1;
        for (int i = 0; i < 40 && MEM_REQ !== 1'b1; i++) @(negedge CLK);
        checks++;
        if (MEM_REQ !== 1'b1 || MEM_ADDR !== m_pc) begin
            errors++;
            $display("FAIL fetch_addr: req=%b addr=%h, expected req=1 addr=%h", MEM_REQ, MEM_ADDR, m_pc);
        end
        repeat (ack_dly) @(negedge CLK);
        MEM_RDATA = instr; MEM_ACK = 1'b1;
        @(negedge CLK);
        MEM_ACK = 1'b0; MEM_RDATA = 16'($urandom);
        checks++;
        if (IR !== instr || EX_START !== 1'b0 || BRANCH_TAKEN !== 1'b0 || BUSY !== 1'b1) begin
            errors++;
            $display("FAIL decode: ir=%h ex=%b bt=%b busy=%b, expected ir=%h ex=0 bt=0 busy=1",
                     IR, EX_START, BRANCH_TAKEN, BUSY, instr);
        end
        ACC_ZERO = az; ACC_NEG = an; RUN = run_next;
        br = instr[15];
        case (instr[14:13])
            2'd0:    tk = 1'b1;
            2'd1:    tk = az;
            2'd2:    tk = an;
            default: tk = !az;
        endcase
        off = instr[10] ? int'(instr[10:0]) - 2048 : int'(instr[10:0]);
        exp_pc = (br && tk) ? 16'(int'(m_pc) + off * 2) : 16'(int'(m_pc) + 2);
        @(negedge CLK);
        checks++;
        if (EX_START !== !br || BRANCH_TAKEN !== (br && tk)) begin
            errors++;
            $display("FAIL exec_pulse: ex=%b bt=%b, expected ex=%b bt=%b",
                     EX_START, BRANCH_TAKEN, !br, br && tk);
        end
        if (!br) begin
            @(negedge CLK);
            checks++;
            if (EX_START !== 1'b0 || BUSY !== 1'b1 || MEM_REQ !== 1'b0) begin
                errors++;
                $display("FAIL wait_ex: ex=%b busy=%b req=%b, expected ex=0 busy=1 req=0",
                         EX_START, BUSY, MEM_REQ);
            end
            repeat (ex_dly) @(negedge CLK);
            EX_DONE = 1'b1;
            @(negedge CLK);
            EX_DONE = 1'b0;
        end else begin
            @(negedge CLK);
        end
        checks++;
        if (PC !== exp_pc || BRANCH_TAKEN !== 1'b0 || EX_START !== 1'b0 ||
            MEM_REQ !== run_next || BUSY !== run_next) begin
            errors++;
            $display("FAIL boundary: pc=%h bt=%b ex=%b req=%b busy=%b, expected pc=%h bt=0 ex=0 req=%b busy=%b",
                     PC, BRANCH_TAKEN, EX_START, MEM_REQ, BUSY, exp_pc, run_next, run_next);
        end
        m_pc = exp_pc;
    endtask

    task automatic goto_pc(input logic [15:0] target, input bit run_next);
        logic [15:0] d;
        d = 16'(target - m_pc);
        d = {d[15], d[15:1]};
        run_instr({5'b10000, d[10:0]}, 1'b0, 1'b0, 0, 0, run_next);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (PC !== 16'h0000 || IR !== 16'h0000 || FAULT !== 1'b0 || BUSY !== 1'b0 ||
            MEM_REQ !== 1'b0 || EX_START !== 1'b0 || BRANCH_TAKEN !== 1'b0) begin
            errors++;
            $display("FAIL reset: pc=%h ir=%h fault=%b busy=%b req=%b, expected all zero",
                     PC, IR, FAULT, BUSY, MEM_REQ);
        end
    endtask

    task automatic test_nonbranch();
        run_instr(16'h1234, 1'b0, 1'b0, 0, 0, 1'b1);
        run_instr(16'h7ABC, 1'b1, 1'b1, 3, 2, 1'b0);
    endtask

    task automatic test_branch();
        goto_pc(16'h0010, 1'b1);
        run_instr(16'h9FFE, 1'b0, 1'b0, 0, 0, 1'b1);
        goto_pc(16'h0020, 1'b1);
        run_instr(16'hA004, 1'b1, 1'b0, 1, 0, 1'b1);
        goto_pc(16'h0020, 1'b1);
        run_instr(16'hA004, 1'b0, 1'b1, 0, 0, 1'b1);
        run_instr(16'hC010, 1'b0, 1'b1, 0, 0, 1'b1);
        run_instr(16'hC010, 1'b1, 1'b0, 0, 0, 1'b1);
        run_instr(16'hE7F0, 1'b0, 1'b0, 2, 0, 1'b1);
        run_instr(16'hE7F0, 1'b1, 1'b1, 0, 0, 1'b0);
    endtask

    task automatic test_wrap();
        goto_pc(16'hFFFE, 1'b1);
        run_instr(16'h0042, 1'b0, 1'b0, 0, 1, 1'b1);
        goto_pc(16'h0002, 1'b1);
        run_instr(16'h8FFE, 1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic test_timeout();
        int n;
        goto_pc(16'h0040, 1'b0);
        RUN = 1'b1;
        for (int i = 0; i < 10 && MEM_REQ !== 1'b1; i++) @(negedge CLK);
        n = 0;
        while (MEM_REQ === 1'b1 && n < 40) begin
            n++;
            @(negedge CLK);
        end
        checks++;
        if (n !== 15 || FAULT !== 1'b1 || BUSY !== 1'b0 || PC !== 16'h0040) begin
            errors++;
            $display("FAIL timeout: cycles=%0d fault=%b busy=%b pc=%h, expected cycles=15 fault=1 busy=0 pc=0040",
                     n, FAULT, BUSY, PC);
        end
        repeat (5) @(negedge CLK);
        checks++;
        if (MEM_REQ !== 1'b0 || BUSY !== 1'b0 || FAULT !== 1'b1) begin
            errors++;
            $display("FAIL fault_sticky: req=%b busy=%b fault=%b, expected req=0 busy=0 fault=1",
                     MEM_REQ, BUSY, FAULT);
        end
        do_reset();
        checks++;
        if (FAULT !== 1'b0 || PC !== 16'h0000) begin
            errors++;
            $display("FAIL fault_clear: fault=%b pc=%h, expected fault=0 pc=0000", FAULT, PC);
        end
    endtask

    task automatic test_reset_mid_fetch();
        goto_pc(16'h0100, 1'b1);
        for (int i = 0; i < 10 && MEM_REQ !== 1'b1; i++) @(negedge CLK);
        RST_N = 1'b0;
        #1;
        checks++;
        if (MEM_REQ !== 1'b0 || PC !== 16'h0000 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: req=%b pc=%h busy=%b, expected req=0 pc=0000 busy=0",
                     MEM_REQ, PC, BUSY);
        end
        RUN = 1'b0; MEM_RDATA = 16'hBEEF; MEM_ACK = 1'b1;
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        MEM_ACK = 1'b0;
        @(negedge CLK);
        checks++;
        if (IR !== 16'h0000 || BUSY !== 1'b0 || MEM_REQ !== 1'b0) begin
            errors++;
            $display("FAIL late_ack: ir=%h busy=%b req=%b, expected ir=0000 busy=0 req=0", IR, BUSY, MEM_REQ);
        end
        m_pc = 16'h0000;
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++) begin
            run_instr(16'($urandom), 1'($urandom), 1'($urandom),
                      int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
                      ($urandom_range(0, 3) != 0));
        end
    endtask

    initial begin
        test_reset();
        test_nonbranch();
        test_branch();
        test_wrap();
        test_timeout();
        test_reset_mid_fetch();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
